// File: rtl/snn_seq_pkg.sv
// Shared types and defaults for the Wishbone command sequencer in front of the
// Neuromorphic_X1 CIM macro.
package snn_seq_pkg;

  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_TIMEOUT = 255;
  localparam int CMD_W           = 69;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_cmd_t;

endpackage

// File: rtl/snn_cmd_fifo.sv
// Command FIFO: DEPTH x 69-bit entries, full/empty from pointers carrying one
// extra wrap bit. The head entry is visible without a read strobe.
module snn_cmd_fifo
  import snn_seq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [CMD_W-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [CMD_W-1:0] head,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CMD_W-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO refuses the push even when a pop happens on the same edge.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/snn_wb_sequencer.sv
// Wishbone classic master that drains a command FIFO into the CIM macro, one
// single cycle at a time, with an ack timeout and one response per command.
module snn_wb_sequencer
  import snn_seq_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  seq_state_e       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_dat_q, rsp_dat_d;
  logic             rsp_err_q, rsp_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  wb_cmd_t          push_cmd;
  wb_cmd_t          head_cmd;
  logic [CMD_W-1:0] head_bits;

  assign push_cmd = '{we: cmd_we, sel: cmd_sel, adr: cmd_adr, dat: cmd_dat};
  assign head_cmd = wb_cmd_t'(head_bits);

  snn_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .head      (head_bits),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cyc_d    = 1'b1;
          we_d     = head_cmd.we;
          sel_d    = head_cmd.sel;
          adr_d    = head_cmd.adr;
          dat_d    = head_cmd.dat;
          cnt_d    = '0;
          state_d  = BUS;
        end
      end
      BUS: begin
        // Ack takes priority over a timeout expiring on the same edge.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (cnt_q == TIMEOUT_C) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_ready = !fifo_full;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_snn_wb_sequencer.sv
// Bench for snn_wb_sequencer: transaction-level reference model checked every
// cycle, a memory-backed Wishbone slave, directed cases plus a random phase.
module tb_snn_wb_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int NEVER   = 1000;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } cmd_s;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } rsp_s;

  logic        wb_clk_i   = 1'b0;
  logic        wb_rst_n_i = 1'b0;
  logic        cmd_valid  = 1'b0;
  logic        cmd_we     = 1'b0;
  logic [3:0]  cmd_sel    = 4'h0;
  logic [31:0] cmd_adr    = 32'h0;
  logic [31:0] cmd_dat    = 32'h0;
  logic        rsp_ready  = 1'b0;
  logic        wbm_ack_i  = 1'b0;
  logic [31:0] wbm_dat_i  = 32'h0;
  logic        cmd_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [7:0]  err_cnt;

  snn_wb_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_sel    (cmd_sel),
    .cmd_adr    (cmd_adr),
    .cmd_dat    (cmd_dat),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dat    (rsp_dat),
    .rsp_err    (rsp_err),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_dat_i  (wbm_dat_i),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slave controls written only by the main process.
  int  slave_delay = 0;
  bit  rand_delay  = 0;
  bit  force_ack   = 0;
  bit  rsp_hold    = 0;
  bit  rsp_rand    = 0;

  // Slave: memory-backed, acks on the (delay+1)-th cycle stb is seen high.
  logic [31:0] mem [16];
  int          sl_n      = 0;
  int          cur_delay = 0;
  bit          wr_pend   = 0;
  logic [3:0]  wr_idx, wr_sel;
  logic [31:0] wr_val;

  always @(posedge wb_clk_i) begin
    #1;
    if (wr_pend) begin
      for (int b = 0; b < 4; b++)
        if (wr_sel[b]) mem[wr_idx][8*b +: 8] = wr_val[8*b +: 8];
      wr_pend = 0;
    end
    wbm_ack_i = 1'b0;
    wbm_dat_i = $urandom();
    if (!wb_rst_n_i) begin
      sl_n      = 0;
      rsp_ready = 1'b0;
    end else begin
      if (wbm_stb_o) sl_n++;
      else begin
        sl_n      = 0;
        cur_delay = rand_delay ? int'($urandom_range(0, TIMEOUT + 3)) : slave_delay;
      end
      if (force_ack) wbm_ack_i = 1'b1;
      else if (wbm_stb_o && sl_n == cur_delay + 1) begin
        wbm_ack_i = 1'b1;
        if (wbm_we_o) begin
          wr_pend = 1;
          wr_idx  = wbm_adr_o[5:2];
          wr_sel  = wbm_sel_o;
          wr_val  = wbm_dat_o;
        end else begin
          wbm_dat_i = mem[wbm_adr_o[5:2]];
        end
      end
      rsp_ready = rsp_hold ? 1'b0 : (rsp_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  // Reference model: commands waiting, the one on the bus, the pending response.
  cmd_s        mq[$];
  rsp_s        rsp_log[$];
  cmd_s        cur;
  bit          bus_on = 0;
  bit          rsp_on = 0;
  int          bus_n  = 0;
  logic [31:0] e_dat  = 32'h0;
  logic        e_err  = 1'b0;
  int          e_errcnt = 0;

  always @(negedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      mq.delete();
      bus_on   = 0;
      rsp_on   = 0;
      bus_n    = 0;
      e_errcnt = 0;
    end else begin
      bit exp_ready;
      bit push;
      exp_ready = (mq.size() < DEPTH);
      chk("cmd_ready", cmd_ready, exp_ready);
      chk("cyc", wbm_cyc_o, bus_on);
      chk("stb", wbm_stb_o, bus_on);
      if (bus_on) begin
        chk("wbm_we", wbm_we_o, cur.we);
        chk("wbm_sel", wbm_sel_o, cur.sel);
        chk("wbm_adr", wbm_adr_o, cur.adr);
        chk("wbm_dat", wbm_dat_o, cur.dat);
      end
      chk("rsp_valid", rsp_valid, rsp_on);
      if (rsp_on) begin
        chk("rsp_dat", rsp_dat, e_dat);
        chk("rsp_err", rsp_err, e_err);
      end
      chk("err_cnt", err_cnt, e_errcnt);
      chk("busy", busy, bus_on || rsp_on || (mq.size() > 0));

      push = cmd_valid && exp_ready;
      if (rsp_on) begin
        if (rsp_ready) begin
          rsp_on = 0;
          rsp_log.push_back('{dat: e_dat, err: e_err});
          $display("rsp %0d: we=%0b adr=%h dat=%h err=%0b", rsp_log.size(),
                   cur.we, cur.adr, e_dat, e_err);
        end
      end else if (bus_on) begin
        bus_n++;
        if (wbm_ack_i) begin
          e_dat  = cur.we ? 32'h0 : wbm_dat_i;
          e_err  = 1'b0;
          bus_on = 0;
          rsp_on = 1;
        end else if (bus_n == TIMEOUT + 1) begin
          e_dat  = 32'h0;
          e_err  = 1'b1;
          if (e_errcnt < 255) e_errcnt++;
          bus_on = 0;
          rsp_on = 1;
        end
      end else if (mq.size() > 0) begin
        cur    = mq.pop_front();
        bus_on = 1;
        bus_n  = 0;
      end
      if (push) mq.push_back('{we: cmd_we, sel: cmd_sel, adr: cmd_adr, dat: cmd_dat});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  // Called and returns one time unit after a rising edge.
  task automatic push(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                      input logic [31:0] dat);
    bit ok = 0;
    int budget = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_sel   = sel;
    cmd_adr   = adr;
    cmd_dat   = dat;
    while (!ok && budget < 400) begin
      @(negedge wb_clk_i);
      ok = cmd_ready;
      @(posedge wb_clk_i);
      #1;
      budget++;
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_mis++;
      $display("FAIL push_wait: got no accept want accept within 400 cycles");
    end
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (!(mq.size() == 0 && !bus_on && !rsp_on) && budget < 3000) begin
      tick(1);
      budget++;
    end
    if (budget >= 3000) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain_wait: got busy want idle within 3000 cycles");
    end
    tick(1);
  endtask

  initial begin
    int base;
    int hi;
    int t;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // Reset state
    repeat (3) @(posedge wb_clk_i);
    #3 wb_rst_n_i = 1'b1;
    #1;
    chk("rst_cyc", wbm_cyc_o, 1'b0);
    chk("rst_stb", wbm_stb_o, 1'b0);
    chk("rst_we", wbm_we_o, 1'b0);
    chk("rst_sel", wbm_sel_o, 4'h0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_dat", wbm_dat_o, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_dat", rsp_dat, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    tick(1);

    // Single write then read, slave acks after 2 cycles
    slave_delay = 2;
    base = rsp_log.size();
    push(1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_0001);
    push(1'b0, 4'hF, 32'h3000_0004, 32'h0);
    wait_drain();
    chk("wr_count", rsp_log.size(), base + 2);
    if (rsp_log.size() == base + 2) begin
      chk("wr_err", rsp_log[base].err, 1'b0);
      chk("wr_dat", rsp_log[base].dat, 32'h0);
      chk("rd_err", rsp_log[base+1].err, 1'b0);
      chk("rd_dat", rsp_log[base+1].dat, 32'hA5A5_0001);
    end

    // Minimum latency with a same-cycle ack
    slave_delay = 0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h3000_0004;
    @(posedge wb_clk_i);
    #1 cmd_valid = 1'b0;
    @(negedge wb_clk_i);
    chk("lat_stb_n0", wbm_stb_o, 1'b0);
    @(negedge wb_clk_i);
    chk("lat_stb_n1", wbm_stb_o, 1'b1);
    chk("lat_cyc_n1", wbm_cyc_o, 1'b1);
    @(negedge wb_clk_i);
    chk("lat_rsp_n2", rsp_valid, 1'b1);
    chk("lat_dat_n2", rsp_dat, 32'hA5A5_0001);
    tick(1);
    wait_drain();

    // Timeout: slave never acks
    slave_delay = NEVER;
    base = rsp_log.size();
    push(1'b1, 4'h3, 32'h3000_0010, 32'hDEAD_BEEF);
    hi = 0;
    t = 0;
    while (!rsp_valid && t < 100) begin
      @(negedge wb_clk_i);
      if (wbm_stb_o) hi++;
      t++;
    end
    chk("to_stb_cycles", hi, TIMEOUT + 1);
    chk("to_rsp_err", rsp_err, 1'b1);
    chk("to_rsp_dat", rsp_dat, 32'h0);
    chk("to_err_cnt", err_cnt, 8'd1);
    chk("to_cyc", wbm_cyc_o, 1'b0);
    tick(1);
    wait_drain();
    force_ack = 1;
    tick(3);
    force_ack = 0;
    tick(3);
    chk("late_ack_count", rsp_log.size(), base + 1);
    chk("late_ack_valid", rsp_valid, 1'b0);

    // Ack on the same edge as the timeout
    slave_delay = TIMEOUT;
    base = rsp_log.size();
    push(1'b0, 4'hF, 32'h3000_0004, 32'h0);
    wait_drain();
    chk("edge_count", rsp_log.size(), base + 1);
    if (rsp_log.size() == base + 1) begin
      chk("edge_err", rsp_log[base].err, 1'b0);
      chk("edge_dat", rsp_log[base].dat, 32'hA5A5_0001);
    end
    chk("edge_err_cnt", err_cnt, 8'd1);

    // FIFO full with the response port stalled
    slave_delay = NEVER;
    rsp_hold = 1;
    base = rsp_log.size();
    for (int i = 0; i < 5; i++) push(1'b1, 4'hF, 32'h3000_0020 + 32'(4 * i), 32'(i + 1));
    @(negedge wb_clk_i);
    chk("full_ready", cmd_ready, 1'b0);
    @(posedge wb_clk_i);
    #1;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 4'hF;
    cmd_adr = 32'h3000_0034; cmd_dat = 32'h6;
    tick(4);
    slave_delay = 1;
    rsp_hold = 0;
    push(1'b1, 4'hF, 32'h3000_0034, 32'h6);
    wait_drain();
    chk("full_count", rsp_log.size(), base + 6);
    if (rsp_log.size() == base + 6) begin
      chk("full_first_err", rsp_log[base].err, 1'b1);
      chk("full_last_err", rsp_log[base+5].err, 1'b0);
    end
    chk("full_err_cnt", err_cnt, 8'd2);

    // Random traffic
    rand_delay = 1;
    rsp_rand = 1;
    for (int i = 0; i < 60; i++) begin
      push(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           32'h3000_0000 | 32'($urandom_range(0, 15) << 2), $urandom());
      tick($urandom_range(0, 2));
    end
    wait_drain();
    rand_delay = 0;
    rsp_rand = 0;

    // Asynchronous reset mid-BUS with commands queued
    slave_delay = NEVER;
    rsp_hold = 1;
    for (int i = 0; i < 4; i++) push(1'b0, 4'hF, 32'h3000_0000 + 32'(4 * i), 32'h0);
    @(posedge wb_clk_i);
    #3 wb_rst_n_i = 1'b0;
    #1;
    chk("arst_cyc", wbm_cyc_o, 1'b0);
    chk("arst_stb", wbm_stb_o, 1'b0);
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    repeat (2) @(posedge wb_clk_i);
    #3 wb_rst_n_i = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_err_cnt", err_cnt, 8'h0);
    chk("arst_cmd_ready", cmd_ready, 1'b1);
    tick(1);
    rsp_hold = 0;
    base = rsp_log.size();
    tick(20);
    chk("arst_no_stale", rsp_log.size(), base);
    slave_delay = 1;
    push(1'b1, 4'h1, 32'h3000_0008, 32'h0000_00C3);
    push(1'b0, 4'hF, 32'h3000_0008, 32'h0);
    wait_drain();
    chk("arst_after_count", rsp_log.size(), base + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
